// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between two requesters.
// A tag pipeline tracks each product and returns it to its originating requester.
module mult_arbiter #(
  parameter int Q1       = 14,
  parameter int Q2       = 16,
  parameter int MULT_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [Q1-1:0]      req0_x1,
  input  logic [Q2-1:0]      req0_x2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [Q1-1:0]      req1_x1,
  input  logic [Q2-1:0]      req1_x2,
  output logic [Q1-1:0]      mult_x1,
  output logic [Q2-1:0]      mult_x2,
  input  logic [Q1+Q2-1:0]   mult_y,
  output logic [Q1+Q2-1:0]   res_y,
  output logic               res0_valid,
  output logic               res1_valid,
  output logic               last_grant
);

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  logic             gnt_vld;
  logic             gnt_id;
  logic [Q1-1:0]    mult_x1_q;
  logic [Q2-1:0]    mult_x2_q;
  logic [Q1-1:0]    mult_x1_d;
  logic [Q2-1:0]    mult_x2_d;
  logic             last_grant_q;
  logic [Q1+Q2-1:0] res_y_q;
  logic             res0_valid_q;
  logic             res1_valid_q;
  // Stage 0 travels with the operand register; stages 1..MULT_LAT track the multiplier.
  tag_t             tag_q [MULT_LAT+1];

  // Readies stay low while reset is held, even if valids are asserted.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant_q;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  always_comb begin
    mult_x1_d = gnt_id ? req1_x1 : req0_x1;
    mult_x2_d = gnt_id ? req1_x2 : req0_x2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_x1_q    <= '0;
      mult_x2_q    <= '0;
      last_grant_q <= 1'b1;
      res_y_q      <= '0;
      res0_valid_q <= 1'b0;
      res1_valid_q <= 1'b0;
      for (int i = 0; i <= MULT_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (gnt_vld) begin
        mult_x1_q    <= mult_x1_d;
        mult_x2_q    <= mult_x2_d;
        last_grant_q <= gnt_id;
      end
      tag_q[0] <= {gnt_vld, gnt_id};
      for (int i = 1; i <= MULT_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      // mult_y holds the tagged product now; capture it with its owner's pulse.
      if (tag_q[MULT_LAT].vld) begin
        res_y_q <= mult_y;
      end
      res0_valid_q <= tag_q[MULT_LAT].vld & ~tag_q[MULT_LAT].id;
      res1_valid_q <= tag_q[MULT_LAT].vld &  tag_q[MULT_LAT].id;
    end
  end

  assign req0_ready = gnt_vld & ~gnt_id;
  assign req1_ready = gnt_vld &  gnt_id;
  assign mult_x1    = mult_x1_q;
  assign mult_x2    = mult_x2_q;
  assign res_y      = res_y_q;
  assign res0_valid = res0_valid_q;
  assign res1_valid = res1_valid_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a MULT_LAT-register signed multiplier model.
module tb_mult_arbiter;
  localparam int Q1  = 14;
  localparam int Q2  = 16;
  localparam int LAT = 2;
  localparam int PW  = Q1 + Q2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [Q1-1:0] req0_x1, req1_x1, mult_x1;
  logic [Q2-1:0] req0_x2, req1_x2, mult_x2;
  logic [PW-1:0] mult_y, res_y;
  logic          res0_valid, res1_valid, last_grant;

  typedef struct packed {
    logic          id;
    logic [PW-1:0] y;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  int            total = 0;
  int            bad   = 0;
  int            n_pulse = 0;
  logic signed [PW-1:0] mpipe [LAT];

  mult_arbiter #(.Q1(Q1), .Q2(Q2), .MULT_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x1(req0_x1), .req0_x2(req0_x2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x1(req1_x1), .req1_x2(req1_x2),
    .mult_x1(mult_x1), .mult_x2(mult_x2), .mult_y(mult_y),
    .res_y(res_y), .res0_valid(res0_valid), .res1_valid(res1_valid), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] prod(input logic [Q1-1:0] a, input logic [Q2-1:0] b);
    logic signed [PW-1:0] sa, sb;
    sa = {{Q2{a[Q1-1]}}, a};
    sb = {{Q1{b[Q2-1]}}, b};
    return sa * sb;
  endfunction

  // Multiplier model: product lands in mult_y LAT edges after the operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= prod(mult_x1, mult_x2);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mult_y = mpipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge; record accepts as expected results.
  task automatic cyc(input logic v0, input logic [Q1-1:0] a0, input logic [Q2-1:0] b0,
                     input logic v1, input logic [Q1-1:0] a1, input logic [Q2-1:0] b1,
                     output logic r0, output logic r1);
    @(negedge clk);
    req0_valid = v0; req0_x1 = a0; req0_x2 = b0;
    req1_valid = v1; req1_x1 = a1; req1_x2 = b1;
    #1;
    r0 = req0_ready;
    r1 = req1_ready;
    chk("rdy_both", {63'd0, r0 & r1}, 64'd0);
    chk("rdy_no_vld", {63'd0, (r0 & ~v0) | (r1 & ~v1)}, 64'd0);
    if (v0 && r0) sbq.push_back('{id: 1'b0, y: prod(a0, b0)});
    if (v1 && r1) sbq.push_back('{id: 1'b1, y: prod(a1, b1)});
  endtask

  task automatic idle(output logic r0, output logic r1);
    cyc(1'b0, '0, '0, 1'b0, '0, '0, r0, r1);
  endtask

  task automatic drain();
    logic r0, r1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) idle(r0, r1);
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && (res0_valid || res1_valid)) begin
      n_pulse++;
      chk("res_both", {63'd0, res0_valid & res1_valid}, 64'd0);
      if (sbq.size() == 0) begin
        chk("res_spurious", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("res_id", {63'd0, res1_valid}, {63'd0, mon_e.id});
        chk("res_y", 64'(res_y), 64'(mon_e.y));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic r0, r1;
    int   cnt, first, last;
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x1 = '0; req0_x2 = '0; req1_x1 = '0; req1_x2 = '0;
    #2 reset = 1'b1;

    // Reset state with both valids high: readies must stay low.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 14'd5, 16'd5, 1'b1, 14'd6, 16'd6, r0, r1);
      chk("rst_rdy", {62'd0, r0, r1}, 64'd0);
    end
    chk("rst_res_y", 64'(res_y), 64'd0);
    chk("rst_mult_x", {34'd0, mult_x1, mult_x2}, 64'd0);
    chk("rst_res_v", {62'd0, res0_valid, res1_valid}, 64'd0);
    chk("rst_last", {63'd0, last_grant}, 64'd1);
    sbq.delete();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;

    // Both valid from reset: grants alternate starting with requester 0.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 14'd64, 16'd128, 1'b1, 14'd100, 16'd3, r0, r1);
      chk("alt_rdy", {62'd0, r0, r1}, (k % 2 == 0) ? 64'd2 : 64'd1);
    end
    drain();
    chk("alt_last", {63'd0, last_grant}, 64'd1);

    // Single accept on req0, check exact latency and pulse width.
    cyc(1'b1, 14'd32, 16'd16, 1'b0, '0, '0, r0, r1);
    chk("single_rdy", {62'd0, r0, r1}, 64'd2);
    for (int k = 1; k <= 5; k++) begin
      idle(r0, r1);
      chk("lat_v0", {63'd0, res0_valid}, (k == 4) ? 64'd1 : 64'd0);
      chk("lat_v1", {63'd0, res1_valid}, 64'd0);
    end
    chk("single_y", 64'(res_y), 64'd512);

    // req1 alone, then both: req0 next, then req1.
    cyc(1'b0, '0, '0, 1'b1, 14'd5, 16'd7, r0, r1);
    chk("r1_alone", {62'd0, r0, r1}, 64'd1);
    cyc(1'b1, 14'd9, 16'd11, 1'b1, 14'd13, 16'd2, r0, r1);
    chk("rr_next0", {62'd0, r0, r1}, 64'd2);
    cyc(1'b1, 14'd9, 16'd11, 1'b1, 14'd13, 16'd2, r0, r1);
    chk("rr_next1", {62'd0, r0, r1}, 64'd1);
    drain();

    // Signed pass-through.
    cyc(1'b1, 14'h3FFF, 16'd2, 1'b0, '0, '0, r0, r1);
    drain();
    chk("signed_y", 64'(res_y), 64'h3FFFFFFE);

    // Reset one cycle after two accepts: no late pulses, priority back to req0.
    cyc(1'b1, 14'd21, 16'd3, 1'b1, 14'd22, 16'd4, r0, r1);
    cyc(1'b1, 14'd21, 16'd3, 1'b1, 14'd22, 16'd4, r0, r1);
    @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    cnt = n_pulse;
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 14'd1, 16'd1, 1'b1, 14'd2, 16'd2, r0, r1);
      chk("mid_rst_rdy", {62'd0, r0, r1}, 64'd0);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst_y", 64'(res_y), 64'd0);
    chk("post_rst_last", {63'd0, last_grant}, 64'd1);
    for (int k = 0; k < 5; k++) idle(r0, r1);
    chk("post_rst_pulses", 64'(n_pulse - cnt), 64'd0);
    cyc(1'b1, 14'd7, 16'd8, 1'b1, 14'd9, 16'd10, r0, r1);
    chk("post_rst_gnt", {62'd0, r0, r1}, 64'd2);
    drain();

    // req0 streaming ten operands: ten back-to-back pulses in order.
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 22; i++) begin
      cyc(i < 10, Q1'(i + 1), 16'd1, 1'b0, '0, '0, r0, r1);
      if (i < 10) chk("stream_rdy", {63'd0, r0}, 64'd1);
      if (res0_valid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_cnt", 64'(cnt), 64'd10);
    chk("stream_gap", 64'(last - first + 1), 64'd10);
    chk("stream_last_y", 64'(res_y), 64'd10);
    chk("stream_last", {63'd0, last_grant}, 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
